// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings,
// byte-enable constants and the default base address.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_e;

    localparam logic [3:0]  BE_WORD  = 4'b1111;
    localparam logic [3:0]  BE_HALF0 = 4'b0011;
    localparam logic [3:0]  BE_HALF1 = 4'b1100;

    localparam logic [31:0] DMR_BASE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take the new data,
// the remaining lanes keep the old word.
module dm_byte_merge #(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0][7:0] old_word,
    input  logic [NUM_LANES-1:0][7:0] wdata,
    input  logic [NUM_LANES-1:0]      be,
    output logic [NUM_LANES-1:0][7:0] merged
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign merged[i] = be[i] ? wdata[i] : old_word[i];
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the Mem stage: accepts one request,
// waits LATENCY cycles, performs the access and pulses a one-cycle response.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE       = DMR_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wr_trace_valid,
    output logic [31:0] wr_trace_pc,
    output logic [31:0] wr_trace_addr,
    output logic [31:0] wr_trace_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    dmr_state_e            state;
    logic [2:0]            cnt;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic [31:0]           pc_q;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           off;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           old_word;
    logic [31:0]           merged;

    // Offset form of the range check: an address below BASE wraps to a huge
    // offset and fails, and BASE + size never has to be formed in 32 bits.
    assign off      = addr_q - BASE;
    assign in_range = {1'b0, off} < (33'd4 << ADDR_WIDTH);
    assign idx      = off[ADDR_WIDTH+1:2];
    assign old_word = mem[idx];

    assign req_ready = reset && (state == DMR_IDLE);

    dm_byte_merge #(.NUM_LANES(4)) u_merge (
        .old_word (old_word),
        .wdata    (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= DMR_IDLE;
            cnt            <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            pc_q           <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            wr_trace_valid <= 1'b0;
            wr_trace_pc    <= '0;
            wr_trace_addr  <= '0;
            wr_trace_data  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                DMR_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        pc_q    <= req_pc;
                        cnt     <= 3'(LATENCY);
                        state   <= DMR_WAIT;
                    end
                end
                DMR_WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        // Access edge: response data and trace are registered here.
                        resp_valid <= 1'b1;
                        resp_err   <= !in_range;
                        resp_rdata <= (!we_q && in_range) ? old_word : 32'h0;
                        if (we_q && in_range && be_q != 4'b0000) begin
                            mem[idx]       <= merged;
                            wr_trace_valid <= 1'b1;
                            wr_trace_pc    <= pc_q;
                            wr_trace_addr  <= {addr_q[31:2], 2'b00};
                            wr_trace_data  <= merged;
                        end
                        state <= DMR_RESP;
                    end
                end
                DMR_RESP: begin
                    resp_valid     <= 1'b0;
                    wr_trace_valid <= 1'b0;
                    state          <= DMR_IDLE;
                end
                default: state <= DMR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: two instances (LATENCY=2 and 0)
// checked against a word-array scoreboard.
module tb_dm_responder;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic [31:0] req_pc    [2];
    logic        resp_valid[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err  [2];
    logic        tr_valid  [2];
    logic [31:0] tr_pc     [2];
    logic [31:0] tr_addr   [2];
    logic [31:0] tr_data   [2];

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(2), .BASE(BASE)) u_l2 (
        .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .req_pc(req_pc[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .wr_trace_valid(tr_valid[0]),
        .wr_trace_pc(tr_pc[0]), .wr_trace_addr(tr_addr[0]), .wr_trace_data(tr_data[0])
    );

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(0), .BASE(BASE)) u_l0 (
        .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .req_pc(req_pc[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .wr_trace_valid(tr_valid[1]),
        .wr_trace_pc(tr_pc[1]), .wr_trace_addr(tr_addr[1]), .wr_trace_data(tr_data[1])
    );

    int          lat [2] = '{2, 0};
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_e0 [2];
    logic [31:0] model [2][DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_model(input int u);
        for (int i = 0; i < DEPTH; i++) model[u][i] = 32'h0;
    endtask

    // One request on unit u, checked cycle by cycle against the scoreboard.
    task automatic issue(input int u, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] pc, input bit hold = 1'b0);
        int          L;
        int          n;
        bit          inr;
        bit          early;
        bit          exp_tr;
        int unsigned widx;
        logic [31:0] exp_rd;
        logic [31:0] mw;
        L = lat[u];
        req_we[u] = we; req_addr[u] = addr; req_wdata[u] = wdata;
        req_be[u] = be; req_pc[u] = pc; req_valid[u] = 1'b1;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[u] !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout u=%0d ready=%b required 1", u, req_ready[u]);
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_e0[u] = cyc;
        req_valid[u] = hold;
        req_we[u] = 1'($urandom); req_addr[u] = $urandom; req_wdata[u] = $urandom;
        req_be[u] = 4'($urandom); req_pc[u] = $urandom;

        inr = (addr >= BASE) && ({1'b0, addr} < ({1'b0, BASE} + 33'(4 * DEPTH)));
        widx = inr ? (addr - BASE) / 4 : 0;
        mw = model[u][widx];
        for (int i = 0; i < 4; i++) if (be[i]) mw[8*i +: 8] = wdata[8*i +: 8];
        exp_tr = we && inr && (be != 4'b0000);
        exp_rd = (!we && inr) ? model[u][widx] : 32'h0;

        early = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (resp_valid[u] || tr_valid[u] || req_ready[u]) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL wait_phase u=%0d addr=%h: valid/ready seen before access, required quiet", u, addr);
        end
        @(negedge clk);
        checks++;
        if (resp_valid[u] !== 1'b1) begin
            failures++;
            $display("FAIL resp_valid u=%0d got=%b exp=1 at cycle %0d after accept", u, resp_valid[u], L + 2);
        end
        checks++;
        if (resp_err[u] !== !inr) begin
            failures++;
            $display("FAIL resp_err u=%0d addr=%h got=%b exp=%b", u, addr, resp_err[u], !inr);
        end
        checks++;
        if (resp_rdata[u] !== exp_rd) begin
            failures++;
            $display("FAIL resp_rdata u=%0d addr=%h got=%h exp=%h", u, addr, resp_rdata[u], exp_rd);
        end
        checks++;
        if (tr_valid[u] !== exp_tr) begin
            failures++;
            $display("FAIL trace_valid u=%0d addr=%h got=%b exp=%b", u, addr, tr_valid[u], exp_tr);
        end
        if (exp_tr) begin
            checks++;
            if (tr_pc[u] !== pc || tr_addr[u] !== {addr[31:2], 2'b00} || tr_data[u] !== mw) begin
                failures++;
                $display("FAIL trace_fields u=%0d got pc=%h addr=%h data=%h exp pc=%h addr=%h data=%h",
                         u, tr_pc[u], tr_addr[u], tr_data[u], pc, {addr[31:2], 2'b00}, mw);
            end
            model[u][widx] = mw;
        end
        @(negedge clk);
        checks++;
        if (resp_valid[u] !== 1'b0 || tr_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
            failures++;
            $display("FAIL resp_end u=%0d got valid=%b trace=%b ready=%b exp 0 0 1",
                     u, resp_valid[u], tr_valid[u], req_ready[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
            req_wdata[u] = '0; req_be[u] = '0; req_pc[u] = '0;
            clear_model(u);
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (req_ready[u] !== 1'b0 || resp_valid[u] !== 1'b0 || resp_err[u] !== 1'b0 ||
                tr_valid[u] !== 1'b0 || resp_rdata[u] !== 32'h0 || tr_data[u] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs u=%0d got ready=%b valid=%b err=%b trace=%b rdata=%h exp all 0",
                         u, req_ready[u], resp_valid[u], resp_err[u], tr_valid[u], resp_rdata[u]);
            end
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (req_ready[u] !== 1'b1) begin
                failures++;
                $display("FAIL reset_release_ready u=%0d got=%b exp=1", u, req_ready[u]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h3004);
        issue(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h3008);
    endtask

    task automatic test_byte_lanes();
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h100);
        issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h104);
        issue(0, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h108);
        issue(0, 1'b1, 32'h20, 32'h55555555, 4'b0000, 32'h10C);
        issue(0, 1'b0, 32'h22, 32'h0, 4'b0000, 32'h110);
    endtask

    task automatic test_range();
        issue(0, 1'b0, 32'h1000, 32'h0, 4'b1111, 32'h200);
        issue(0, 1'b1, 32'h0FFC, 32'hCAFEF00D, 4'b1111, 32'h204);
        issue(0, 1'b0, 32'h0FFC, 32'h0, 4'b1111, 32'h208);
        issue(0, 1'b1, 32'h1004, 32'h12345678, 4'b1111, 32'h20C);
        issue(0, 1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'b1111, 32'h210);
    endtask

    task automatic test_back_to_back(input int u);
        int e_first;
        issue(u, 1'b1, 32'h30, 32'h0BADF00D, 4'b1111, 32'h300, 1'b1);
        e_first = last_e0[u];
        issue(u, 1'b0, 32'h30, 32'h0, 4'b1111, 32'h304);
        checks++;
        if (last_e0[u] - e_first !== lat[u] + 3) begin
            failures++;
            $display("FAIL accept_spacing u=%0d got=%0d exp=%0d", u, last_e0[u] - e_first, lat[u] + 3);
        end
    endtask

    task automatic test_latency0();
        issue(1, 1'b1, 32'h84, 32'h600DCAFE, 4'b1111, 32'h400);
        issue(1, 1'b0, 32'h84, 32'h0, 4'b0000, 32'h404);
        issue(1, 1'b1, 32'h84, 32'hFFFF0000, 4'b1100, 32'h408);
        issue(1, 1'b0, 32'h84, 32'h0, 4'b0000, 32'h40C);
    endtask

    task automatic test_reset_mid_wait();
        bit bad;
        int n;
        req_we[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'h77777777;
        req_be[0] = 4'b1111; req_pc[0] = 32'h500; req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #1 rst_n[0] = 1'b0;
        clear_model(0);
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b0 || tr_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got valid=%b trace=%b ready=%b exp 0 0 0",
                     resp_valid[0], tr_valid[0], req_ready[0]);
        end
        rst_n[0] = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[0] || tr_valid[0] || !req_ready[0]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL mid_reset_dropped: response/trace seen or ready low after release, exp quiet and ready=1");
        end
        issue(0, 1'b0, 32'h40, 32'h0, 4'b1111, 32'h504);
        issue(0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h508);
    endtask

    task automatic test_random(input int u, input int count);
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, 63)) << 2;
            else if (sel < 9)  a = 32'h0FF0 + 32'($urandom_range(0, 31));
            else               a = $urandom;
            issue(u, 1'($urandom), a, $urandom, 4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
        end
        issue(u, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_range();
        test_back_to_back(0);
        test_latency0();
        test_back_to_back(1);
        test_reset_mid_wait();
        test_random(0, 40);
        test_random(1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, exp completion");
        $fatal(1, "timeout");
    end

endmodule
